// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one 32-bit combinational ALU
// among N_REQ requesters. A request is accepted in IDLE and executed in
// EXEC. Its result is then held in RESP until the consumer takes it.
module alu_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [3*N_REQ-1:0]    req_op,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_data,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    // Shared ALU. Arithmetic wraps modulo 2^32. No flags are produced.
    function automatic logic [31:0] alu_f(input logic [2:0]  op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] y;
        case (op)
            3'b000:  y = a;
            3'b001:  y = a + b;
            3'b010:  y = a - b;
            3'b011:  y = a & b;
            3'b100:  y = a | b;
            3'b101:  y = a + 32'd1;
            3'b110:  y = a - 32'd1;
            3'b111:  y = b;
            default: y = 32'd0;
        endcase
        return y;
    endfunction

    state_t          state_r;
    state_t          state_s;
    logic [ID_W-1:0] rr_ptr_r;
    logic [ID_W-1:0] rr_ptr_nxt_s;
    logic [2:0]      op_r;
    logic [31:0]     a_r;
    logic [31:0]     b_r;
    logic [ID_W-1:0] id_r;
    logic [31:0]     rsp_data_r;
    logic [ID_W-1:0] rsp_id_r;
    logic            rsp_valid_r;
    logic            busy_r;
    logic [ID_W-1:0] gnt_s;
    logic            gnt_vld_s;
    logic [ID_W-1:0] idx_s;
    logic [2:0]      sel_op_s;
    logic [31:0]     sel_a_s;
    logic [31:0]     sel_b_s;
    logic [31:0]     alu_y_s;

    // Round-robin search from rr_ptr upward with wrap. The loop runs from the
    // far end down to rr_ptr, so the last hit is the one nearest rr_ptr.
    always_comb begin
        gnt_s     = '0;
        gnt_vld_s = 1'b0;
        idx_s     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx_s = ID_W'((int'(rr_ptr_r) + k) % N_REQ);
            if (req_valid[idx_s]) begin
                gnt_s     = idx_s;
                gnt_vld_s = 1'b1;
            end else begin
                gnt_s     = gnt_s;
                gnt_vld_s = gnt_vld_s;
            end
        end
    end

    // Operand mux that selects the granted requester's opcode and operands.
    always_comb begin
        sel_op_s = 3'b000;
        sel_a_s  = 32'd0;
        sel_b_s  = 32'd0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_s == ID_W'(k)) begin
                sel_op_s = req_op[3*k +: 3];
                sel_a_s  = req_a[32*k +: 32];
                sel_b_s  = req_b[32*k +: 32];
            end else begin
                sel_op_s = sel_op_s;
                sel_a_s  = sel_a_s;
                sel_b_s  = sel_b_s;
            end
        end
    end

    // One-hot accept strobe. It is high only in IDLE, only outside reset,
    // and only for the granted requester.
    always_comb begin
        req_ready = '0;
        if ((state_r == IDLE) && gnt_vld_s && rst_n) begin
            req_ready[gnt_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state logic for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (gnt_vld_s) begin
                    state_s = EXEC;
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: state_s = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Pointer to the requester after the one just served, wrapping at N_REQ.
    always_comb begin
        if (id_r == ID_W'(N_REQ - 1)) begin
            rr_ptr_nxt_s = '0;
        end else begin
            rr_ptr_nxt_s = id_r + ID_W'(1);
        end
    end

    assign alu_y_s = alu_f(op_r, a_r, b_r);

    // State register, with registered copies of rsp_valid and busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            rsp_valid_r <= (state_s == RESP);
            busy_r      <= (state_s != IDLE);
        end
    end

    // Capture the granted request on the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r <= 3'b000;
            a_r  <= 32'd0;
            b_r  <= 32'd0;
            id_r <= '0;
        end else if ((state_r == IDLE) && gnt_vld_s) begin
            op_r <= sel_op_s;
            a_r  <= sel_a_s;
            b_r  <= sel_b_s;
            id_r <= gnt_s;
        end else begin
            op_r <= op_r;
            a_r  <= a_r;
            b_r  <= b_r;
            id_r <= id_r;
        end
    end

    // Register the ALU result and owner ID in EXEC. Both stay stable through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_r <= 32'd0;
            rsp_id_r   <= '0;
        end else if (state_r == EXEC) begin
            rsp_data_r <= alu_y_s;
            rsp_id_r   <= id_r;
        end else begin
            rsp_data_r <= rsp_data_r;
            rsp_id_r   <= rsp_id_r;
        end
    end

    // Advance the round-robin pointer only when a response handshake completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= '0;
        end else if ((state_r == RESP) && rsp_ready) begin
            rr_ptr_r <= rr_ptr_nxt_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_id    = rsp_id_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter (N_REQ = 4).
module tb_alu_share_arbiter;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N_REQ-1:0]     req_valid;
    logic [3*N_REQ-1:0]   req_op;
    logic [32*N_REQ-1:0]  req_a;
    logic [32*N_REQ-1:0]  req_b;
    logic [N_REQ-1:0]     req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [31:0]          rsp_data;
    logic                 busy;

    int errors = 0;
    int checks = 0;

    alu_share_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Wait, bounded, until rsp_valid is high at a sample point.
    task automatic wait_valid(output bit to);
        to = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (rsp_valid === 1'b1) begin
                to = 1'b0;
                break;
            end
            tick();
        end
    endtask

    // Issue one request from requester r with every other requester idle.
    // Returns the response and completes the handshake.
    task automatic issue(input int r, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] d,
                         output logic [ID_W-1:0] id, output bit to);
        req_valid = '0;
        req_valid[r] = 1'b1;
        req_op[3*r +: 3] = op;
        req_a[32*r +: 32] = a;
        req_b[32*r +: 32] = b;
        rsp_ready = 1'b1;
        tick();
        req_valid = '0;
        wait_valid(to);
        d  = rsp_data;
        id = rsp_id;
        tick();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rsp_data !== 32'd0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        do_reset();
    endtask

    task automatic test_single_add();
        bit to;
        req_valid = 4'b0001;
        req_op[2:0] = 3'b001;
        req_a[31:0] = 32'd5;
        req_b[31:0] = 32'd7;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_req_ready_c0: got %b expected 0001", req_ready); end
        tick();
        req_valid = '0;
        checks++; if (req_ready !== 4'b0000 || busy !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL single_c1: got ready=%b busy=%b valid=%b expected 0000/1/0", req_ready, busy, rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid_c2: got %b expected 1", rsp_valid); end
        checks++; if (rsp_data !== 32'd12 || rsp_id !== 2'd0) begin errors++; $display("FAIL single_data_c2: got %h id %0d expected 0000000c id 0", rsp_data, rsp_id); end
        tick();
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL single_c3: got busy=%b valid=%b expected 0/0", busy, rsp_valid); end
        wait_valid(to);
    endtask

    task automatic test_round_robin();
        bit to;
        int exp_id[9] = '{0, 1, 2, 3, 0, 2, 3, 0, 2};
        do_reset();
        for (int i = 0; i < N_REQ; i++) begin
            req_op[3*i +: 3] = 3'b111;
            req_a[32*i +: 32] = 32'hDEAD_0000;
            req_b[32*i +: 32] = 32'(i);
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int n = 0; n < 9; n++) begin
            wait_valid(to);
            checks++;
            if (to) begin
                errors++; $display("FAIL rr_timeout: response %0d got none expected id %0d", n, exp_id[n]);
            end else begin
                if (rsp_id !== ID_W'(exp_id[n])) begin errors++; $display("FAIL rr_id: response %0d got %0d expected %0d", n, rsp_id, exp_id[n]); end
                checks++;
                if (rsp_data !== 32'(exp_id[n])) begin errors++; $display("FAIL rr_data: response %0d got %h expected %h", n, rsp_data, 32'(exp_id[n])); end
                if (n == 4) req_valid = 4'b1101;
                tick();
            end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        bit to;
        do_reset();
        req_op[2:0] = 3'b001; req_a[31:0] = 32'd1; req_b[31:0] = 32'd2;
        req_op[5:3] = 3'b000; req_a[63:32] = 32'd99; req_b[63:32] = 32'd0;
        req_valid = 4'b0011;
        rsp_ready = 1'b0;
        tick();
        req_valid = 4'b0010;
        wait_valid(to);
        checks++; if (to) begin errors++; $display("FAIL bp_timeout: got no rsp_valid expected 1"); end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'd3 || rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
                errors++; $display("FAIL bp_hold: cycle %0d got v=%b d=%h id=%0d rdy=%b expected 1/00000003/0/0000", k, rsp_valid, rsp_data, rsp_id, req_ready);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin errors++; $display("FAIL bp_after: got v=%b rdy=%b expected 0/0010", rsp_valid, req_ready); end
        tick();
        req_valid = '0;
        wait_valid(to);
        checks++; if (to || rsp_id !== 2'd1 || rsp_data !== 32'd99) begin errors++; $display("FAIL bp_next: got id=%0d d=%h expected 1/00000063", rsp_id, rsp_data); end
        tick();
    endtask

    task automatic test_wrap();
        logic [31:0] d; logic [ID_W-1:0] id; bit to;
        do_reset();
        issue(0, 3'b101, 32'hFFFF_FFFF, 32'd0, d, id, to);
        checks++; if (to || d !== 32'h0000_0000) begin errors++; $display("FAIL wrap_inc: got %h expected 00000000", d); end
        issue(1, 3'b110, 32'd0, 32'd0, d, id, to);
        checks++; if (to || d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_dec: got %h expected ffffffff", d); end
        issue(3, 3'b010, 32'd3, 32'd5, d, id, to);
        checks++; if (to || d !== 32'hFFFF_FFFE || id !== 2'd3) begin errors++; $display("FAIL wrap_sub: got %h id %0d expected fffffffe id 3", d, id); end
    endtask

    task automatic test_all_ops();
        logic [31:0] d; logic [ID_W-1:0] id; bit to;
        logic [31:0] exp_y[8] = '{32'hF0F000FF, 32'hFFFF1000, 32'hE1E0F1FE, 32'h00000001,
                                  32'hFFFF0FFF, 32'hF0F00100, 32'hF0F000FE, 32'h0F0F0F01};
        for (int op = 0; op < 8; op++) begin
            issue(0, 3'(op), 32'hF0F0_00FF, 32'h0F0F_0F01, d, id, to);
            checks++;
            if (to || d !== exp_y[op]) begin errors++; $display("FAIL op_%0d: got %h expected %h", op, d, exp_y[op]); end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] d; logic [ID_W-1:0] id; bit to;
        req_valid = 4'b1000;
        req_op[11:9] = 3'b001; req_a[127:96] = 32'd10; req_b[127:96] = 32'd20;
        rsp_ready = 1'b1;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy); end
        req_valid = 4'b1111;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 32'd0 || rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL mid_reset_out: got busy=%b v=%b d=%h id=%0d rdy=%b expected 0/0/0/0/0000", busy, rsp_valid, rsp_data, rsp_id, req_ready);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_valid: cycle %0d got %b expected 0", k, rsp_valid); end
        end
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_ptr_zero: got %b expected 0001", req_ready); end
        req_valid = '0;
        tick();
        issue(2, 3'b011, 32'hFF00_FF00, 32'h0FF0_0FF0, d, id, to);
        checks++; if (to || id !== 2'd2 || d !== 32'h0F00_0F00) begin errors++; $display("FAIL mid_after: got id=%0d d=%h expected 2/0f000f00", id, d); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_all_ops();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one instance of the team's 32-bit combinational ALU among N_REQ requesters. The ALU takes a 3-bit Op_code and operands A and B and produces Y.
- Each requester presents an opcode and two operands with a valid/ready handshake.
- A round-robin arbiter grants one request at a time, sequences it through the ALU and returns a registered result tagged with the requester ID under valid/ready backpressure.
- Sits between the issue logic of several client blocks and the single ALU datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(N_REQ), width of the requester ID field.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  N_REQ  bit i: requester i has a request.
- req_op  in  3*N_REQ  slice [3i+2:3i] is requester i's ALU opcode.
- req_a  in  32*N_REQ  slice [32i+31:32i] is requester i's operand A.
- req_b  in  32*N_REQ  slice [32i+31:32i] is requester i's operand B.
- req_ready  out  N_REQ  one-hot; bit i high means requester i is accepted this cycle.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_data  out  32  ALU result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (rst_n low, asynchronous):
  - state=IDLE, rr_ptr=0.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - Captured op, A and B registers = 0.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - If req_valid==0, stay in IDLE.
  - Otherwise grant g = the first set bit of req_valid searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., N_REQ-1, 0, ...).
  - req_ready[g]=1 combinationally in this cycle only; all other bits stay 0.
  - On the clock edge: capture op/A/B of g, set id_q=g, go to EXEC.
- EXEC: ALU is driven from the captured registers. Register Y into rsp_data and id_q into rsp_id, then go to RESP.
- RESP:
  - rsp_valid=1.
  - rsp_data and rsp_id hold stable until rsp_valid && rsp_ready.
  - On the handshake: go to IDLE, rsp_valid drops next cycle, rr_ptr = (g+1) mod N_REQ.
- req_ready is 0 in EXEC and RESP. Requests arriving then wait, and requesters must hold their inputs stable until accepted.
- Timing:
  - Latency: accept edge T, rsp_valid high in cycle T+2.
  - Minimum issue interval is 3 cycles (accept, EXEC, RESP with rsp_ready=1). The next acceptance is possible in the cycle after the RESP handshake.
- ALU opcode semantics:
  - 000 → A
  - 001 → A+B
  - 010 → A-B
  - 011 → A&B
  - 100 → A|B
  - 101 → A+1
  - 110 → A-1
  - 111 → B
- Arithmetic is 32-bit modulo 2^32. No carry, flags or overflow are produced.
- Fairness: a continuously asserting requester is served within N_REQ grants. A requester that drops req_valid before being accepted loses its turn with no side effects.
- rr_ptr advances only on a completed response, never on an idle cycle.
- rsp_ready held low indefinitely: the block stalls in RESP and no new request is accepted.
- Reset mid-operation (any state): return to IDLE asynchronously. The in-flight result is discarded, rsp_valid=0, rr_ptr=0.
- busy=1 in EXEC and RESP.

Test Plan:
- Single request, add: req_valid=4'b0001, op=001, A=5, B=7, rsp_ready=1 → req_ready=0001 in cycle 0; rsp_valid at cycle 2 with rsp_data=12, rsp_id=0; busy low again at cycle 3.
- Round-robin rotation: all four valid continuously, op=111, B=i → responses in ID order 0,1,2,3,0 with rsp_data=i. Then drop requester 1 → next sequence is 2,3,0,2.
- Backpressure: rsp_ready=0 for 10 cycles during RESP → rsp_valid, rsp_data and rsp_id are constant, req_ready=0 throughout. Raise rsp_ready → one handshake, then the next grant.
- Wrap-around arithmetic:
  - op=101, A=32'hFFFFFFFF → 0.
  - op=110, A=0 → 32'hFFFFFFFF.
  - op=010, A=3, B=5 → 32'hFFFFFFFE.
- All opcodes: A=32'hF0F0_00FF, B=32'h0F0F_0F01 for op 000..111 → F0F000FF, FFFF1000, E1E0F1FE, 00000001, FFFF0FFF, F0F00100, F0F000FE, 0F0F0F01.
- Reset mid-operation: assert rst_n=0 while in EXEC → outputs return to their reset values immediately, no rsp_valid appears. After release, a request from requester 2 with the others idle gets rsp_id=2.
